// File: rtl/uart_tx_fifo_if.sv
// Byte push port for uart_tx_fifo: producer drives tx_data/tx_valid, block answers tx_ready.
// Latency: none, this is wiring only.
// Backpressure: tx_ready low means the byte on tx_data is not taken this edge.
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 (8E1 with UART_TX_PARITY_EN) UART serialiser, LSB first.
// Latency: byte pushed into an idle, empty block is popped next edge; ser_tx falls after it.
// Backpressure: tx_ready = !full; frames run back to back while bytes are queued.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                   clock,
  input  logic                   resetb,
  input  logic [DIV_W-1:0]       clk_div,
  uart_tx_fifo_if.slave          tx,
  output logic                   ser_tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]       LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PAR   = 3'd3,
`endif
    S_STOP  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q, level_d;
  logic [7:0]        shift_q, shift_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  cyc_q, cyc_d;
  logic [2:0]        bit_q, bit_d;
  logic              ser_q, ser_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic fifo_empty, push, pop, bit_end;

  assign fifo_empty = (level_q == '0);
  assign tx.tx_ready = (level_q != LVL_FULL);
  assign push       = tx.tx_valid && tx.tx_ready;
  assign bit_end    = (cyc_q == div_q);
  // Head is taken when the serialiser is idle or finishing a stop bit.
  assign pop        = !fifo_empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

  assign ser_tx     = ser_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_level = level_q;

  // FIFO storage; contents need no reset since level_q gates every read.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= tx.tx_data;
  end

  // Occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (!push && pop) level_d = level_q - LVL_ONE;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_d;
    end
  end

  // Bit timing: load shifter and latch divider at pop, count cycles per bit, shift after each data bit.
  always_comb begin
    shift_d = shift_q;
    div_d   = div_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      div_d   = clk_div;
      cyc_d   = '0;
      bit_d   = '0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^mem_q[rd_ptr_q];
`endif
    end else if (state_q != S_IDLE) begin
      if (bit_end) begin
        cyc_d = '0;
        if (state_q == S_DATA) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
        end
      end else begin
        cyc_d = cyc_q + DIV_ONE;
      end
    end
  end

  // Datapath and serial output registers; ser_tx comes straight from a flop.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      shift_q <= '0;
      div_q   <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      ser_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      div_q   <= div_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      ser_q   <= ser_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: each non-idle state lasts div+1 cycles per bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:  if (bit_end && (bit_q == 3'd7)) state_d = S_PAR;
      S_PAR:   if (bit_end) state_d = S_STOP;
`else
      S_DATA:  if (bit_end && (bit_q == 3'd7)) state_d = S_STOP;
`endif
      S_STOP:  if (bit_end) state_d = fifo_empty ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output: line level for the coming cycle, registered into ser_q.
  always_comb begin
    ser_d = 1'b1;
    case (state_d)
      S_START: ser_d = 1'b0;
      S_DATA:  ser_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PAR:   ser_d = par_d;
`endif
      default: ser_d = 1'b1;
    endcase
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-wide UART transmitter for the user project area. It drives the serial line that the testbench UART receiver samples, for example mprj_io[6].
- Firmware or LA logic pushes bytes through a valid/ready port into a small FIFO.
- A bit-timing FSM serialises each byte as 8N1, LSB first, at a runtime-programmable bit period.
- This block is the transmitting end of the UART link used for test reporting.

Parameters:
- DEPTH, 4, FIFO entries. Power of 2, minimum 2.
- DIV_W, 16, width of the bit-period divider input.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- resetb  input  1  asynchronous, active-low reset.
- clk_div  input  DIV_W  bit period minus one, in clock cycles. Bit period = clk_div+1.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  FIFO can accept a byte; equals !full.
- ser_tx  output  1  serial line out; idles high.
- busy  output  1  high when the FSM is not IDLE or the FIFO is not empty.
- fifo_level  output  $clog2(DEPTH)+1  number of bytes in the FIFO, excluding the byte in the shifter.

Behaviour:
- Reset (resetb low, takes effect asynchronously):
  - ser_tx=1, tx_ready=1, busy=0, fifo_level=0.
  - FSM goes to IDLE; FIFO pointers and bit/cycle counters clear.
  - Asserting reset mid-frame aborts the frame at once; ser_tx returns high without a stop bit.
- Push: a byte is written on any rising edge where tx_valid && tx_ready. tx_data need only be stable at that edge. When full, tx_ready=0 and tx_valid is ignored.
- Pop: the FSM pops the FIFO head when it is in IDLE, or at the last cycle of STOP, and the FIFO is non-empty. The popped byte loads a shift register. clk_div is latched at the pop; a clk_div change mid-frame affects only later frames.
- Push and pop on the same edge: both happen and fifo_level is unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: ser_tx=1. If the FIFO is non-empty, pop and go to START.
  - START: ser_tx=0 for clk_div+1 cycles, then go to DATA.
  - DATA: ser_tx=shift[0] for clk_div+1 cycles per bit, then shift right. A 3-bit counter ends the state after bit 7.
  - STOP: ser_tx=1 for clk_div+1 cycles. At the last cycle, pop and go to START if the FIFO is non-empty, otherwise go to IDLE.
- Latency: a byte accepted at edge E0 into an empty FIFO with the FSM in IDLE is popped at E1; ser_tx falls after E1.
- Frame length is exactly 10*(clk_div+1) cycles. Back-to-back frames have no idle gap between them.
- clk_div=0 gives 1-cycle bits and is legal.
- ser_tx is driven from a flop (glitch-free).
- Capacity: with the FSM busy, DEPTH bytes fit in the FIFO plus 1 in the shifter.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: an even-parity bit is sent between DATA bit 7 and STOP. The parity bit is the XOR of the 8 data bits and lasts clk_div+1 cycles. Frame length becomes 11*(clk_div+1).
- Undefined: no parity state exists, and the frame is plain 8N1.

Test Plan:
- Single byte: clk_div=3, push 0xA5 into the idle block.
  - Expect ser_tx = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, 40 cycles total.
  - busy drops the cycle after STOP ends; fifo_level stays 0 throughout.
- Back-to-back: clk_div=1, push 0x00 then 0xFF on consecutive cycles.
  - Expect 40 contiguous cycles: start, 8 zeros, stop, start, 8 ones, stop, with no idle cycle between frames.
- Full FIFO: DEPTH=4, clk_div=100, hold tx_valid for 8 cycles with bytes 0x01..0x08.
  - Expect 0x01..0x05 accepted (0x01 to the shifter, 4 to the FIFO), tx_ready=0 from the 6th cycle, fifo_level=4.
  - After all frames, only 0x01..0x05 appear on ser_tx, in order.
- clk_div change: start 0x3C with clk_div=3, then set clk_div=7 during DATA, with 0x3C's successor already queued.
  - Expect 0x3C to take 40 cycles and the next frame to take 80 cycles.
- Reset mid-frame: push 0xF0 and 0x0F, then drop resetb during bit 2 of the first frame.
  - Expect ser_tx=1, fifo_level=0, busy=0, tx_ready=1 immediately, without waiting for a clock edge.
  - After release, no further frame is sent.
- Parity (UART_TX_PARITY_EN defined), clk_div=0:
  - 0xA5: 11-cycle frame, parity bit 0.
  - 0x07: parity bit 1.
